// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multi-cycle MIPS control path.
//   Opcode / funct encodings, ALU function codes, branch_kind codes,
//   FSM state encoding (also exported on the debug 'state' port) and small
//   decode helpers used by multicycle_control and alu_op_decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_LUI  = 6'b001111;

  localparam logic [2:0] BK_BEQ  = 3'd0;
  localparam logic [2:0] BK_BNE  = 3'd1;
  localparam logic [2:0] BK_BLEZ = 3'd2;
  localparam logic [2:0] BK_BGTZ = 3'd3;
  localparam logic [2:0] BK_BGEZ = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL_LINK = 4'd12,
    S_HALT     = 4'd13,
    S_ERROR    = 4'd14
  } state_t;

  // Successor of DECODE for a given instruction.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_SYSCALL) ? S_HALT : S_EXEC_R;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: return S_EXEC_I;
      OP_LW, OP_LB, OP_SW, OP_SB: return S_MEM_ADDR;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ: return S_BRANCH;
      OP_J: return S_JUMP;
      OP_JAL: return S_JAL_LINK;
      default: return S_ERROR;
    endcase
  endfunction

  function automatic logic [5:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDIU: return ALU_ADDU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      OP_SLTI:  return ALU_SLT;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] branch_kind_of(input logic [5:0] op);
    case (op)
      OP_BNE:  return BK_BNE;
      OP_BLEZ: return BK_BLEZ;
      OP_BGTZ: return BK_BGTZ;
      OP_BGEZ: return BK_BGEZ;
      default: return BK_BEQ;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// alu_op_decoder: combinational ALU function select for the multi-cycle FSM.
//   state  : current FSM state
//   opcode : opcode latched in DECODE
//   func   : funct latched in DECODE
//   alu_op : ALU function code (R-type passes funct through)
module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 6
) (
  input  state_t              state,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    alu_op = '0;
    case (state)
      // FETCH: PC+4, DECODE: branch target, MEM_ADDR: rs+imm
      S_FETCH, S_DECODE, S_MEM_ADDR: alu_op = ALU_OP_W'(ALU_ADD);
      S_EXEC_R:                      alu_op = ALU_OP_W'(func);
      S_EXEC_I:                      alu_op = ALU_OP_W'(imm_alu_op(opcode));
      S_BRANCH:                      alu_op = ALU_OP_W'(ALU_SUB);
      default:                       alu_op = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
//   Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath strobes per state,
//   waits on mem_ready with an optional timeout, flags illegal opcodes
//   (illegal_op), memory timeouts (bus_err) and SYSCALL (halted).
// Ports:
//   clk, rst (sync, active high); opcode/func from IR (sampled in DECODE);
//   mem_ready handshake; PC controls pc_write/pc_write_cond/pc_source/
//   branch_kind; memory controls ir_write/mem_read/mem_write_en/i_or_d;
//   ALU controls alu_src_a/alu_src_b/alu_op; register file controls
//   reg_dst/mem_to_reg/reg_write; debug state; sticky flags.
// Configuration: define JAL_LINK_EN to make JAL write PC+4 into $31;
//   otherwise JAL behaves exactly like J.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned ALU_OP_W    = 6,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  func,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic [2:0]          branch_kind,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write_en,
  output logic                i_or_d,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic [3:0]          state,
  output logic                illegal_op,
  output logic                bus_err,
  output logic                halted
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [5:0]          op_q, fn_q;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic                waiting, timeout_hit;
  logic                set_illegal, set_bus, set_halt;
  logic [ALU_OP_W-1:0] dec_alu_op;

  assign state = state_q;

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_op_decoder (
    .state  (state_q),
    .opcode (op_q),
    .func   (fn_q),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      op_q       <= '0;
      fn_q       <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (state_q == S_DECODE) begin
        op_q <= 6'(opcode);
        fn_q <= 6'(func);
      end
      if (set_illegal) illegal_op <= 1'b1;
      if (set_bus)     bus_err    <= 1'b1;
      if (set_halt)    halted     <= 1'b1;
    end
  end

  // The limit cycle itself counts as a wait cycle, so the FSM leaves for
  // ERROR after exactly MEM_TIMEOUT cycles without mem_ready.
  assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_bus     = 1'b0;
    set_halt    = 1'b0;
    wait_d      = (MEM_TIMEOUT != 0 && waiting && !mem_ready) ? wait_cnt + WAIT_W'(1) : '0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d     = decode_next(6'(opcode), 6'(func));
        set_illegal = (state_d == S_ERROR);
        set_halt    = (state_d == S_HALT);
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = is_store(op_q) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL_LINK: state_d = S_FETCH;
      S_HALT, S_ERROR: state_d = state_q;
      default:    state_d = S_ERROR;
    endcase
    if (timeout_hit) begin
      state_d = S_ERROR;
      set_bus = 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    branch_kind   = 3'd0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write_en  = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    alu_op        = rst ? '0 : dec_alu_op;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
          end
        end
        S_DECODE:   alu_src_b = 2'd3;
        S_EXEC_R:   alu_src_a = 1'b1;
        S_WB_R: begin
          reg_dst   = 2'd1;
          reg_write = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_WB_I:     reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          mem_to_reg = 2'd1;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_en = 1'b1;
          i_or_d       = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          branch_kind   = branch_kind_of(op_q);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
        S_JAL_LINK: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
`ifdef JAL_LINK_EN
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
          reg_write  = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
